// File: rtl/dqs_dly_scan.sv
// dqs_dly_scan: sweeps the DQS output delay through all 32 taps, finds the widest
// contiguous passing window and leaves the delay programmed at its centre.
module dqs_dly_scan #(
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLES       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dly_ready,
   input  logic       rcv,
   input  logic       exp,
   output logic [4:0] delay,
   output logic       ld,
   output logic       set,
   output logic       busy,
   output logic       done,
   output logic       found,
   output logic [4:0] win_first,
   output logic [5:0] win_len,
   output logic [4:0] center
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_WAIT_RDY  = 4'd1;
   localparam logic [3:0] S_LOAD      = 4'd2;
   localparam logic [3:0] S_APPLY     = 4'd3;
   localparam logic [3:0] S_SETTLE    = 4'd4;
   localparam logic [3:0] S_SAMPLE    = 4'd5;
   localparam logic [3:0] S_EVAL      = 4'd6;
   localparam logic [3:0] S_FIN_LOAD  = 4'd7;
   localparam logic [3:0] S_FIN_APPLY = 4'd8;
   localparam logic [3:0] S_DONE      = 4'd9;

   localparam logic [4:0] LAST_TAP = 5'd31;

   logic [3:0] state_r, state_s;
   logic [4:0] tap_r, tap_s;
   logic [7:0] cnt_r, cnt_s;
   logic       flag_r, flag_s;
   logic [5:0] cur_len_r, cur_len_s;
   logic [4:0] cur_first_r, cur_first_s;
   logic [5:0] best_len_r, best_len_s;
   logic [4:0] best_first_r, best_first_s;
   logic       abort_s;

   logic [4:0] delay_r;
   logic       ld_r;
   logic       set_r;
   logic       busy_r;
   logic       done_r;
   logic       found_r;
   logic [4:0] win_first_r;
   logic [5:0] win_len_r;
   logic [4:0] center_r;

   // Window centre rounds down for even lengths; an empty window maps to tap 0.
   function automatic logic [4:0] center_of(input logic [4:0] first, input logic [5:0] len);
      logic [5:0] sum;
      sum = {1'b0, first} + ((len - 6'd1) >> 3'd1);
      if (len == 6'd0) begin
         center_of = 5'd0;
      end else begin
         center_of = sum[4:0];
      end
   endfunction

   // Loss of delay-ready anywhere in the tap sequence aborts the sweep.
   always_comb begin
      abort_s = 1'b0;
      case (state_r)
         S_LOAD, S_APPLY, S_SETTLE, S_SAMPLE, S_EVAL, S_FIN_LOAD, S_FIN_APPLY: abort_s = ~dly_ready;
         default: abort_s = 1'b0;
      endcase
   end

   // Next-state and sweep bookkeeping.
   always_comb begin
      state_s      = state_r;
      tap_s        = tap_r;
      cnt_s        = cnt_r;
      flag_s       = flag_r;
      cur_len_s    = cur_len_r;
      cur_first_s  = cur_first_r;
      best_len_s   = best_len_r;
      best_first_s = best_first_r;
      if (abort_s) begin
         state_s      = S_WAIT_RDY;
         tap_s        = 5'd0;
         cur_len_s    = 6'd0;
         cur_first_s  = 5'd0;
         best_len_s   = 6'd0;
         best_first_s = 5'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  state_s      = S_WAIT_RDY;
                  tap_s        = 5'd0;
                  cur_len_s    = 6'd0;
                  cur_first_s  = 5'd0;
                  best_len_s   = 6'd0;
                  best_first_s = 5'd0;
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_WAIT_RDY: begin
               if (dly_ready) begin
                  state_s = S_LOAD;
               end else begin
                  state_s = S_WAIT_RDY;
               end
            end
            S_LOAD: state_s = S_APPLY;
            S_APPLY: begin
               state_s = S_SETTLE;
               cnt_s   = 8'(SETTLE_CYCLES - 1);
               flag_s  = 1'b0;
            end
            S_SETTLE: begin
               if (cnt_r == 8'd0) begin
                  state_s = S_SAMPLE;
                  cnt_s   = 8'(SAMPLES - 1);
               end else begin
                  cnt_s = cnt_r - 8'd1;
               end
            end
            S_SAMPLE: begin
               flag_s = flag_r | (rcv ^ exp);
               if (cnt_r == 8'd0) begin
                  state_s = S_EVAL;
               end else begin
                  cnt_s = cnt_r - 8'd1;
               end
            end
            S_EVAL: begin
               if (!flag_r) begin
                  if (cur_len_r == 6'd0) begin
                     cur_first_s = tap_r;
                  end else begin
                     cur_first_s = cur_first_r;
                  end
                  cur_len_s = cur_len_r + 6'd1;
               end else begin
                  cur_len_s = cur_len_r;
               end
               // Strict compare keeps the earliest window on a tie.
               if (flag_r || (tap_r == LAST_TAP)) begin
                  if (cur_len_s > best_len_r) begin
                     best_len_s   = cur_len_s;
                     best_first_s = cur_first_s;
                  end else begin
                     best_len_s   = best_len_r;
                  end
                  cur_len_s = 6'd0;
               end else begin
                  best_len_s = best_len_r;
               end
               if (tap_r == LAST_TAP) begin
                  state_s = S_FIN_LOAD;
               end else begin
                  tap_s   = tap_r + 5'd1;
                  state_s = S_LOAD;
               end
            end
            S_FIN_LOAD:  state_s = S_FIN_APPLY;
            S_FIN_APPLY: state_s = S_DONE;
            S_DONE:      state_s = S_IDLE;
            default:     state_s = S_IDLE;
         endcase
      end
   end

   // Sequencer state and sweep bookkeeping registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= S_IDLE;
         tap_r        <= 5'd0;
         cnt_r        <= 8'd0;
         flag_r       <= 1'b0;
         cur_len_r    <= 6'd0;
         cur_first_r  <= 5'd0;
         best_len_r   <= 6'd0;
         best_first_r <= 5'd0;
      end else begin
         state_r      <= state_s;
         tap_r        <= tap_s;
         cnt_r        <= cnt_s;
         flag_r       <= flag_s;
         cur_len_r    <= cur_len_s;
         cur_first_r  <= cur_first_s;
         best_len_r   <= best_len_s;
         best_first_r <= best_first_s;
      end
   end

   // Outputs are registered from the state being entered so they line up with it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         delay_r     <= 5'd0;
         ld_r        <= 1'b0;
         set_r       <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         found_r     <= 1'b0;
         win_first_r <= 5'd0;
         win_len_r   <= 6'd0;
         center_r    <= 5'd0;
      end else begin
         ld_r   <= (state_s == S_LOAD) || (state_s == S_FIN_LOAD);
         set_r  <= (state_s == S_APPLY) || (state_s == S_FIN_APPLY);
         busy_r <= (state_s != S_IDLE);
         done_r <= (state_s == S_DONE);
         if (state_s == S_LOAD) begin
            delay_r <= tap_s;
         end else if (state_s == S_FIN_LOAD) begin
            delay_r <= center_of(best_first_s, best_len_s);
         end else begin
            delay_r <= delay_r;
         end
         // Results are published once per completed sweep and then held.
         if (state_s == S_FIN_LOAD) begin
            found_r     <= (best_len_s != 6'd0);
            win_first_r <= best_first_s;
            win_len_r   <= best_len_s;
            center_r    <= center_of(best_first_s, best_len_s);
         end else begin
            found_r     <= found_r;
            win_first_r <= win_first_r;
            win_len_r   <= win_len_r;
            center_r    <= center_r;
         end
      end
   end

   assign delay     = delay_r;
   assign ld        = ld_r;
   assign set       = set_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign found     = found_r;
   assign win_first = win_first_r;
   assign win_len   = win_len_r;
   assign center    = center_r;

endmodule

// File: tb/tb_dqs_dly_scan.sv
// tb_dqs_dly_scan: table of sweep scenarios with randomized DQS data, checked
// cycle by cycle against the expected sweep timeline and a window-search model.
`timescale 1ns/1ps
module tb_dqs_dly_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       dly_ready;
   logic       rcv_b;
   logic       exp_b;
   logic [4:0] delay;
   logic       ld;
   logic       set;
   logic       busy;
   logic       done;
   logic       found;
   logic [4:0] win_first;
   logic [5:0] win_len;
   logic [4:0] center;

   dqs_dly_scan dut (
      .clk(clk), .rst(rst), .start(start), .dly_ready(dly_ready),
      .rcv(rcv_b), .exp(exp_b), .delay(delay), .ld(ld), .set(set),
      .busy(busy), .done(done), .found(found), .win_first(win_first),
      .win_len(win_len), .center(center)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pass_mask;
      bit          sparse;
      int          drop_tap;
      bit          poke_start;
      bit          found_e;
      int          first_e;
      int          len_e;
      int          center_e;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          sweep_base = 0;
   bit          in_sweep = 1'b0;
   bit          in_drop = 1'b0;
   bit          sparse_cur = 1'b0;
   logic [31:0] pass_cur = 32'd0;
   int          goff [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {6'd0, delay, ld, set, busy, done, found, win_first, win_len, center};
   endfunction

   // Longest run of passing taps, earliest run on a tie.
   function automatic void ref_window(input logic [31:0] pm, output int f, output int l);
      int run_s;
      int run_l;
      f = 0; l = 0; run_s = 0; run_l = 0;
      for (int t = 0; t < 32; t++) begin
         if (pm[t]) begin
            if (run_l == 0) run_s = t;
            run_l++;
            if (run_l > l) begin
               l = run_l;
               f = run_s;
            end
         end else begin
            run_l = 0;
         end
      end
   endfunction

   // One clock: drive data after the edge, return at the falling edge for checks.
   // Inside a tap's compare window a failing tap mismatches (on every cycle, or on
   // one random cycle when sparse); everywhere else the data is random noise.
   task automatic step();
      bit mis;
      int r;
      int t;
      int o;
      @(posedge clk);
      cyc++;
      #1;
      exp_b = 1'($urandom_range(0, 1));
      mis   = 1'($urandom_range(0, 1));
      if (in_sweep && !in_drop && cyc >= sweep_base) begin
         r = cyc - sweep_base;
         t = r / 27;
         o = r % 27;
         if (t < 32 && o >= 10 && o <= 25) mis = !pass_cur[t] && (!sparse_cur || o == goff[t]);
      end
      rcv_b = exp_b ^ mis;
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int         c0;
      int         r;
      int         restore_at;
      bit         dropped;
      bit         finished;
      logic [3:0] ctl_e;
      pass_cur   = v.pass_mask;
      sparse_cur = v.sparse;
      for (int t = 0; t < 32; t++) goff[t] = int'($urandom_range(10, 25));
      dropped    = 1'b0;
      finished   = 1'b0;
      restore_at = -1;
      start      = 1'b1;
      c0         = cyc;
      sweep_base = c0 + 2;
      in_sweep   = 1'b1;
      in_drop    = 1'b0;
      for (int k = 0; k < 2000 && !finished; k++) begin
         step();
         start = 1'b0;
         r = cyc - sweep_base;
         ctl_e[3] = !in_drop && ((r >= 0 && r < 864 && r % 27 == 0) || r == 864);
         ctl_e[2] = !in_drop && ((r >= 1 && r < 864 && r % 27 == 1) || r == 865);
         ctl_e[1] = !in_drop && (r == 866);
         ctl_e[0] = in_drop || (r <= 866);
         chk($sformatf("v%0d ld/set/done/busy", idx), {28'd0, ld, set, done, busy}, {28'd0, ctl_e});
         if (ctl_e[3] || ctl_e[2])
            chk($sformatf("v%0d delay", idx), 32'(delay), (r >= 864) ? v.center_e : r / 27);
         if (!in_drop && r == 867) begin
            chk($sformatf("v%0d found", idx), 32'(found), 32'(v.found_e));
            chk($sformatf("v%0d win_first", idx), 32'(win_first), v.first_e);
            chk($sformatf("v%0d win_len", idx), 32'(win_len), v.len_e);
            chk($sformatf("v%0d center", idx), 32'(center), v.center_e);
            chk($sformatf("v%0d final delay", idx), 32'(delay), v.center_e);
            finished = 1'b1;
         end else begin
            if (v.poke_start && !dropped && r == 100) start = 1'b1;
            if (v.drop_tap >= 0 && !dropped && r == 27 * v.drop_tap + 15) begin
               dly_ready  = 1'b0;
               in_drop    = 1'b1;
               dropped    = 1'b1;
               restore_at = cyc + 6;
            end else if (in_drop && cyc == restore_at) begin
               dly_ready  = 1'b1;
               in_drop    = 1'b0;
               sweep_base = cyc + 1;
            end
         end
      end
      start = 1'b0;
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL v%0d timeout: sweep end not reached within 2000 cycles", idx);
      end
      in_sweep = 1'b0;
      repeat (3) step();
      chk($sformatf("v%0d results held", idx),
          {16'd0, found, win_first, win_len, center},
          {16'd0, v.found_e, 5'(v.first_e), 6'(v.len_e), 5'(v.center_e)});
   endtask

   initial begin
      vec_t vecs [11];
      int   f;
      int   l;
      rst = 1'b0; start = 1'b0; dly_ready = 1'b1; rcv_b = 1'b0; exp_b = 1'b0;

      vecs[0] = '{32'hFFFF_FFFF, 1'b0, -1, 1'b0, 1'b1, 0, 32, 15};
      vecs[1] = '{32'h0003_FC00, 1'b0, -1, 1'b0, 1'b1, 10, 8, 13};
      vecs[2] = '{32'h00F0_003C, 1'b0, -1, 1'b0, 1'b1, 2, 4, 3};
      vecs[3] = '{32'h00F0_0034, 1'b1, -1, 1'b0, 1'b1, 20, 4, 21};
      vecs[4] = '{32'h0000_0000, 1'b0, -1, 1'b0, 1'b0, 0, 0, 0};
      vecs[5] = '{32'h0003_FC00, 1'b1, 7, 1'b0, 1'b1, 10, 8, 13};
      vecs[6] = '{32'hFFFF_0000, 1'b0, -1, 1'b1, 1'b1, 16, 16, 23};
      for (int i = 7; i < 11; i++) begin
         case (i)
            7:       vecs[i].pass_mask = ~(32'd1 << $urandom_range(0, 31));
            8:       vecs[i].pass_mask = $urandom | $urandom;
            9:       vecs[i].pass_mask = ~($urandom & $urandom & $urandom);
            default: vecs[i].pass_mask = $urandom;
         endcase
         vecs[i].sparse     = 1'($urandom_range(0, 1));
         vecs[i].drop_tap   = -1;
         vecs[i].poke_start = 1'b0;
         ref_window(vecs[i].pass_mask, f, l);
         vecs[i].found_e  = (l != 0);
         vecs[i].first_e  = f;
         vecs[i].len_e    = l;
         vecs[i].center_e = (l == 0) ? 0 : (f + (l - 1) / 2) % 32;
      end

      repeat (3) step();
      chk("reset outputs", all_outs(), 32'd0);
      rst = 1'b1;
      step();
      chk("idle outputs", all_outs(), 32'd0);

      run_vec(vecs[0], 0);

      // Reset in the middle of the compare window of tap 2.
      pass_cur = 32'hFFFF_FFFF; sparse_cur = 1'b0; in_sweep = 1'b1;
      start = 1'b1; sweep_base = cyc + 2;
      step();
      start = 1'b0;
      repeat (70) step();
      chk("mid-sample busy", 32'(busy), 32'd1);
      rst = 1'b0;
      step();
      chk("reset mid-sample", all_outs(), 32'd0);
      step();
      rst = 1'b1;
      in_sweep = 1'b0;
      repeat (3) begin
         step();
         chk("idle after reset", all_outs(), 32'd0);
      end

      for (int i = 1; i < 11; i++) run_vec(vecs[i], i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
